// File: rtl/modn_chain_cnt.sv
// modn_chain_cnt: cascaded modulo-MOD counter with DIGITS digits.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low clear of q, wrap, load_err
//   pause     1 holds the count
//   up        1 counts up, 0 counts down
//   load      parallel load strobe (wins over pause and count)
//   load_val  load value, digit k at [k*W +: W]
//   q         registered count, same packing as load_val
//   tc        combinational terminal count (cascade enable)
//   wrap      registered one-cycle roll pulse
//   load_err  registered one-cycle out-of-range load pulse
module modn_chain_cnt #(
    parameter int MOD      = 10,
    parameter int DIGITS   = 2,
    parameter int W        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pause,
    input  logic                up,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    output logic [DIGITS*W-1:0] q,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    localparam logic [W-1:0] DMAX = W'(MOD - 1);
    // One extra bit so a field equal to 2**W-1 can be
    // compared against MOD without truncation.
    localparam logic [W:0]   DMOD = (W+1)'(MOD);

    // cy_up[k]: all digits below k are at MOD-1.
    // cy_dn[k]: all digits below k are at 0.
    logic [DIGITS:0]     cy_up;
    logic [DIGITS:0]     cy_dn;
    logic                at_lim;
    logic [DIGITS*W-1:0] cnt_nx;
    logic [DIGITS*W-1:0] ld_nx;
    logic                ld_bad;

    always_comb begin
        cy_up[0] = 1'b1;
        cy_dn[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            cy_up[k+1] = cy_up[k] & (q[k*W +: W] == DMAX);
            cy_dn[k+1] = cy_dn[k] & (q[k*W +: W] == '0);
        end
    end

    assign at_lim = up ? cy_up[DIGITS] : cy_dn[DIGITS];
    assign tc     = at_lim & ~pause & ~load;

    // At the limit every digit is enabled and rolls,
    // so the wrap value falls out of the per-digit rule.
    always_comb begin
        cnt_nx = q;
        for (int k = 0; k < DIGITS; k++) begin
            if (up && cy_up[k]) begin
                if (q[k*W +: W] == DMAX)
                    cnt_nx[k*W +: W] = '0;
                else
                    cnt_nx[k*W +: W] = q[k*W +: W] + W'(1);
            end else if (!up && cy_dn[k]) begin
                if (q[k*W +: W] == '0)
                    cnt_nx[k*W +: W] = DMAX;
                else
                    cnt_nx[k*W +: W] = q[k*W +: W] - W'(1);
            end
        end
    end

    // Out-of-range fields load 0 in that digit only.
    always_comb begin
        ld_nx  = load_val;
        ld_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if ({1'b0, load_val[k*W +: W]} >= DMOD) begin
                ld_nx[k*W +: W] = '0;
                ld_bad          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            q        <= ld_nx;
            wrap     <= 1'b0;
            load_err <= ld_bad;
        end else if (pause) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (SATURATE && at_lim) begin
                wrap <= 1'b0;
            end else begin
                q    <= cnt_nx;
                wrap <= at_lim & ~SATURATE;
            end
        end
    end

endmodule
